pwm_channel_bank: RTL and testbench

PWM_CHANNEL_BANK -- requirements
Module: pwm_channel_bank

---
 rtl/pwm_channel_bank.sv | 164 ++++++++++++++++
 tb/tb_pwm_channel_bank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_channel_bank.sv
// Purpose: bank of CHANNELS independent waveform generators (divide, PWM, one-shot, off) with shadow/active period and pulse registers.
// Ports:   clk/reset (sync, active-high); wr_chan + write_period/write_pulse/write_mode strobes with period_i/pulse_i/mode_i data;
//          out_enable gates clk_o per channel; clk_o, period_done, busy are registered per-channel outputs.
// Latency: every output is registered from the count of the previous cycle, so waveforms and period_done trail the count by one cycle.
module pwm_channel_bank #(
    parameter int CHANNELS     = 4,
    parameter int COUNTER_BITS = 32,
    parameter int PULSE_BITS   = 32,
    localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        wr_chan,
    input  logic                    write_period,
    input  logic                    write_pulse,
    input  logic                    write_mode,
    input  logic [COUNTER_BITS-1:0] period_i,
    input  logic [PULSE_BITS-1:0]   pulse_i,
    input  logic [1:0]              mode_i,
    input  logic [CHANNELS-1:0]     out_enable,
    output logic [CHANNELS-1:0]     clk_o,
    output logic [CHANNELS-1:0]     period_done,
    output logic [CHANNELS-1:0]     busy
);

    // Common width for count/pulse compares; the narrower operand is zero-extended.
    localparam int CMP_W = (COUNTER_BITS > PULSE_BITS) ? COUNTER_BITS : PULSE_BITS;

    // One-shot is split into running and finished so a completed shot idles until the next mode write.
    typedef enum logic [2:0] {
        ST_OFF,
        ST_DIV,
        ST_PWM,
        ST_OS_RUN,
        ST_OS_DONE
    } state_t;

    state_t                  state_q   [CHANNELS];
    state_t                  state_d   [CHANNELS];
    logic [COUNTER_BITS-1:0] count_q   [CHANNELS];
    logic [COUNTER_BITS-1:0] count_d   [CHANNELS];
    logic [COUNTER_BITS-1:0] sh_per_q  [CHANNELS];
    logic [COUNTER_BITS-1:0] sh_per_d  [CHANNELS];
    logic [COUNTER_BITS-1:0] act_per_q [CHANNELS];
    logic [COUNTER_BITS-1:0] act_per_d [CHANNELS];
    logic [PULSE_BITS-1:0]   sh_pul_q  [CHANNELS];
    logic [PULSE_BITS-1:0]   sh_pul_d  [CHANNELS];
    logic [PULSE_BITS-1:0]   act_pul_q [CHANNELS];
    logic [PULSE_BITS-1:0]   act_pul_d [CHANNELS];

    // raw_q is the ungated waveform; keeping it separate from clk_o_q lets the
    // divider keep toggling while the output is gated, so re-enable is in phase.
    logic [CHANNELS-1:0] raw_q,   raw_d;
    logic [CHANNELS-1:0] clk_o_q, clk_o_d;
    logic [CHANNELS-1:0] done_q,  done_d;
    logic [CHANNELS-1:0] busy_q,  busy_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            count_d[i]   = count_q[i];
            sh_per_d[i]  = sh_per_q[i];
            sh_pul_d[i]  = sh_pul_q[i];
            act_per_d[i] = act_per_q[i];
            act_pul_d[i] = act_pul_q[i];
            raw_d[i]     = raw_q[i];
            done_d[i]    = 1'b0;
            busy_d[i]    = 1'b0;

            // Out-of-range wr_chan values match no channel and are dropped.
            if (wr_chan == SEL_W'(i) && write_period) sh_per_d[i] = period_i;
            if (wr_chan == SEL_W'(i) && write_pulse)  sh_pul_d[i] = pulse_i;

            case (state_q[i])
                ST_DIV, ST_PWM: begin
                    if (state_q[i] == ST_PWM)
                        raw_d[i] = (CMP_W'(count_q[i]) < CMP_W'(act_pul_q[i]));
                    if (count_q[i] == act_per_q[i]) begin
                        // Wrap: shadow_q (not shadow_d) is loaded, so a write in
                        // the wrap cycle itself waits for the following wrap.
                        count_d[i]   = '0;
                        done_d[i]    = 1'b1;
                        act_per_d[i] = sh_per_q[i];
                        act_pul_d[i] = sh_pul_q[i];
                        if (state_q[i] == ST_DIV) raw_d[i] = ~raw_q[i];
                    end else begin
                        count_d[i] = count_q[i] + 1'b1;
                    end
                end
                ST_OS_RUN: begin
                    if (CMP_W'(count_q[i]) < CMP_W'(act_pul_q[i])) begin
                        raw_d[i]   = 1'b1;
                        busy_d[i]  = 1'b1;
                        count_d[i] = count_q[i] + 1'b1;
                    end else begin
                        raw_d[i]   = 1'b0;
                        done_d[i]  = 1'b1;
                        state_d[i] = ST_OS_DONE;
                    end
                end
                ST_OS_DONE: begin
                    raw_d[i] = 1'b0;
                end
                default: begin
                    raw_d[i]   = 1'b0;
                    count_d[i] = '0;
                end
            endcase

            // Mode write restarts the channel using the just-written shadow values.
            if (wr_chan == SEL_W'(i) && write_mode) begin
                act_per_d[i] = sh_per_d[i];
                act_pul_d[i] = sh_pul_d[i];
                count_d[i]   = '0;
                raw_d[i]     = 1'b0;
                done_d[i]    = 1'b0;
                busy_d[i]    = 1'b0;
                case (mode_i)
                    2'b00:   state_d[i] = ST_DIV;
                    2'b01:   state_d[i] = ST_PWM;
                    2'b10:   state_d[i] = ST_OS_RUN;
                    default: state_d[i] = ST_OFF;
                endcase
            end

            clk_o_d[i] = raw_d[i] & out_enable[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]   <= ST_OFF;
                count_q[i]   <= '0;
                sh_per_q[i]  <= '0;
                sh_pul_q[i]  <= '0;
                act_per_q[i] <= '0;
                act_pul_q[i] <= '0;
            end
            raw_q   <= '0;
            clk_o_q <= '0;
            done_q  <= '0;
            busy_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]   <= state_d[i];
                count_q[i]   <= count_d[i];
                sh_per_q[i]  <= sh_per_d[i];
                sh_pul_q[i]  <= sh_pul_d[i];
                act_per_q[i] <= act_per_d[i];
                act_pul_q[i] <= act_pul_d[i];
            end
            raw_q   <= raw_d;
            clk_o_q <= clk_o_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign clk_o       = clk_o_q;
    assign period_done = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Purpose: scenario bench for pwm_channel_bank; expected per-cycle outputs are queued as stimulus is applied and popped each cycle.
// Timing:  inputs change and outputs are sampled on the falling clock edge; k counts cycles after the relevant write edge.
// Ports:   default parameters (4 channels, 32-bit counter and pulse).
module tb_pwm_channel_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wr_chan;
    logic        write_period, write_pulse, write_mode;
    logic [31:0] period_i, pulse_i;
    logic [1:0]  mode_i;
    logic [3:0]  out_enable;
    logic [3:0]  clk_o, period_done, busy;

    typedef struct {
        int   ch;
        int   k;
        logic c;
        logic d;
        logic b;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pwm_channel_bank dut (
        .clk          (clk),
        .reset        (reset),
        .wr_chan      (wr_chan),
        .write_period (write_period),
        .write_pulse  (write_pulse),
        .write_mode   (write_mode),
        .period_i     (period_i),
        .pulse_i      (pulse_i),
        .mode_i       (mode_i),
        .out_enable   (out_enable),
        .clk_o        (clk_o),
        .period_done  (period_done),
        .busy         (busy)
    );

    function automatic exp_t mk(int ch, int k, logic c, logic d, logic b);
        exp_t r;
        r.ch = ch; r.k = k; r.c = c; r.d = d; r.b = b;
        return r;
    endfunction

    // Strobes are high for exactly one cycle; returns in the first cycle after the write edge (k=0).
    task automatic do_write(input int ch, input logic wp, input logic wl, input logic wm,
                            input logic [31:0] per, input logic [31:0] pul, input logic [1:0] md);
        @(negedge clk);
        wr_chan = ch[1:0]; write_period = wp; write_pulse = wl; write_mode = wm;
        period_i = per; pulse_i = pul; mode_i = md;
        @(negedge clk);
        write_period = 1'b0; write_pulse = 1'b0; write_mode = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++)
            for (int ch = 0; ch < 4; ch++) exp_q.push_back(mk(ch, k, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int ch = 0; ch < 4; ch++) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                    n_errors++;
                    $display("FAIL reset k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                             clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
                end
            end
        end
    endtask

    // ch0 period 3: toggle every 4 cycles, period_done every 4 cycles.
    task automatic test_divide;
        do_write(0, 1'b1, 1'b0, 1'b1, 32'd3, 32'd0, 2'b00);
        for (int k = 1; k <= 24; k++)
            exp_q.push_back(mk(0, k, logic'((k / 4) % 2), logic'(k % 4 == 0), 1'b0));
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                n_errors++;
                $display("FAIL divide k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                         clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
            end
        end
    endtask

    // ch1 period 9 pulse 3, all three strobes in one cycle: 3 high, 7 low.
    task automatic test_pwm;
        do_write(1, 1'b1, 1'b1, 1'b1, 32'd9, 32'd3, 2'b01);
        for (int k = 1; k <= 30; k++)
            exp_q.push_back(mk(1, k, logic'((k - 1) % 10 < 3), logic'(k % 10 == 0), 1'b0));
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                n_errors++;
                $display("FAIL pwm k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                         clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
            end
        end
    endtask

    // Continues ch1: pulse 5 written in the cycle where count is 4 (k=34).
    task automatic test_shadow;
        for (int k = 31; k <= 52; k++)
            exp_q.push_back(mk(1, k, (k <= 40) ? logic'((k - 1) % 10 < 3) : logic'((k - 1) % 10 < 5),
                               logic'(k % 10 == 0), 1'b0));
        for (int k = 31; k <= 52; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                n_errors++;
                $display("FAIL shadow k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                         clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
            end
            if (k == 34) begin
                wr_chan = 2'd1; pulse_i = 32'd5; write_pulse = 1'b1;
            end else if (k == 35) begin
                write_pulse = 1'b0;
            end
        end
    endtask

    // Continues ch1 (pulse 5): output gated for 12 cycles, period_done keeps going.
    task automatic test_gating;
        for (int k = 53; k <= 80; k++)
            exp_q.push_back(mk(1, k, (k >= 56 && k <= 67) ? 1'b0 : logic'((k - 1) % 10 < 5),
                               logic'(k % 10 == 0), 1'b0));
        for (int k = 53; k <= 80; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                n_errors++;
                $display("FAIL gating k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                         clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
            end
            if (k == 55) out_enable[1] = 1'b0;
            if (k == 67) out_enable[1] = 1'b1;
        end
    endtask

    // ch3: pulse > period is constant high, pulse 0 constant low.
    task automatic test_pwm_bounds;
        do_write(3, 1'b1, 1'b1, 1'b1, 32'd2, 32'd7, 2'b01);
        for (int k = 1; k <= 9; k++) exp_q.push_back(mk(3, k, 1'b1, logic'(k % 3 == 0), 1'b0));
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                n_errors++;
                $display("FAIL pwm_high k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                         clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
            end
        end
        do_write(3, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 2'b01);
        for (int k = 1; k <= 9; k++) exp_q.push_back(mk(3, k, 1'b0, logic'(k % 3 == 0), 1'b0));
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                n_errors++;
                $display("FAIL pwm_low k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                         clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
            end
        end
    endtask

    // ch2 one-shot pulse 4, then ch3 one-shot pulse 0; neither retriggers.
    task automatic test_oneshot;
        do_write(2, 1'b0, 1'b1, 1'b1, 32'd0, 32'd4, 2'b10);
        for (int k = 1; k <= 14; k++)
            exp_q.push_back(mk(2, k, logic'(k <= 4), logic'(k == 5), logic'(k <= 4)));
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                n_errors++;
                $display("FAIL oneshot k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                         clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
            end
        end
        do_write(3, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 2'b10);
        for (int k = 1; k <= 6; k++) exp_q.push_back(mk(3, k, 1'b0, logic'(k == 1), 1'b0));
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                n_errors++;
                $display("FAIL oneshot0 k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                         clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
            end
        end
    endtask

    // Reset while ch0/ch1 run, with a competing one-shot write to ch2; then
    // a bare mode write on ch0 must see the cleared (zero) period.
    task automatic test_reset_mid;
        @(negedge clk);
        reset = 1'b1;
        wr_chan = 2'd2; pulse_i = 32'd4; write_pulse = 1'b1; mode_i = 2'b10; write_mode = 1'b1;
        @(negedge clk);
        reset = 1'b0; write_pulse = 1'b0; write_mode = 1'b0;
        for (int k = 0; k <= 15; k++)
            for (int ch = 0; ch < 4; ch++) exp_q.push_back(mk(ch, k, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k <= 15; k++) begin
            if (k > 0) @(negedge clk);
            for (int ch = 0; ch < 4; ch++) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                    n_errors++;
                    $display("FAIL reset_mid k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                             clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
                end
            end
        end
        do_write(0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 2'b00);
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back(mk(0, k, logic'(k % 2), 1'b1, 1'b0));
            exp_q.push_back(mk(2, k, 1'b0, 1'b0, 1'b0));
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({clk_o[e.ch], period_done[e.ch], busy[e.ch]} !== {e.c, e.d, e.b}) begin
                    n_errors++;
                    $display("FAIL restart k=%0d ch%0d clk/done/busy got %b%b%b want %b%b%b", e.k, e.ch,
                             clk_o[e.ch], period_done[e.ch], busy[e.ch], e.c, e.d, e.b);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        wr_chan = '0; write_period = 1'b0; write_pulse = 1'b0; write_mode = 1'b0;
        period_i = '0; pulse_i = '0; mode_i = 2'b11; out_enable = 4'hF;
        test_reset();
        test_divide();
        test_pwm();
        test_shadow();
        test_gating();
        test_pwm_bounds();
        test_oneshot();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
